// File: rtl/local_bus_pkg.sv
// Shared definitions for the local bus timeout watchdog: state encoding,
// default timing parameters and a small sizing helper.
package local_bus_pkg;

    // Default clocks allowed from TSn to termination before an error is forced.
    localparam int TIMEOUT_CLKS_DEF = 1023;

    // Default idle clocks enforced after a forced error.
    localparam int RECOVER_CLKS_DEF = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ERR     = 2'd2,
        RECOVER = 2'd3
    } lbt_state_e;

    // Larger of two integers, used to size the shared cycle counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/local_bus_timeout_if.sv
// Bus-side signal bundle for the timeout watchdog. The master modport is the
// Amiga/target side driving the bus, the slave modport is the watchdog.
interface local_bus_timeout_if;

    logic       TSn;
    logic       TACKn;
    logic       TEAn;
    logic [1:0] A_AMIGA;
    logic       TO_EN;
    logic       CNT_CLR;
    logic       TO_TEAn;
    logic       TO_BUSY;
    logic [7:0] TO_CNT;
    logic [1:0] TO_ADDR;

    modport master (
        output TSn, TACKn, TEAn, A_AMIGA, TO_EN, CNT_CLR,
        input  TO_TEAn, TO_BUSY, TO_CNT, TO_ADDR
    );

    modport slave (
        input  TSn, TACKn, TEAn, A_AMIGA, TO_EN, CNT_CLR,
        output TO_TEAn, TO_BUSY, TO_CNT, TO_ADDR
    );

endinterface

// File: rtl/lb_timeout_ctr.sv
// Up-counter shared by the WAIT timeout and the RECOVER hold-off. Load clears
// it to zero, enable advances it, tc flags that the count equals limit.
module lb_timeout_ctr #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: load has priority over enable; otherwise hold.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == limit);

endmodule

// File: rtl/local_bus_timeout.sv
// Local bus watchdog: opens a monitored cycle on TSn, and if neither TACKn
// nor TEAn arrives within TIMEOUT_CLKS clocks, drives a one-clock TO_TEAn,
// logs the cycle address and bumps a saturating fault counter, then holds
// off for RECOVER_CLKS clocks. TO_TEAn is ANDed with the target TEAn by the
// enclosing design before it reaches the sizing state machine.
module local_bus_timeout
    import local_bus_pkg::*;
#(
    parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF,
    parameter int RECOVER_CLKS = RECOVER_CLKS_DEF   // must be at least 1
) (
    input  logic                CLK40,
    input  logic                RESETn,
    local_bus_timeout_if.slave  bus
);

    // One counter serves both WAIT and RECOVER, so size it for the longer.
    localparam int CTR_W = $clog2(max_int(TIMEOUT_CLKS, RECOVER_CLKS) + 1);
    localparam logic [CTR_W-1:0] TO_LIMIT = CTR_W'(TIMEOUT_CLKS - 1);
    localparam logic [CTR_W-1:0] RC_LIMIT = CTR_W'(RECOVER_CLKS - 1);

    lbt_state_e state_q, state_d;
    logic [1:0] shadow_q, shadow_d;
    logic       to_tean_q, to_tean_d;
    logic       to_busy_q, to_busy_d;
    logic [7:0] to_cnt_q, to_cnt_d;
    logic [1:0] to_addr_q, to_addr_d;

    logic             ctr_load;
    logic             ctr_en;
    logic [CTR_W-1:0] ctr_limit;
    logic             ctr_tc;

    logic ts_seen;
    logic term_seen;

    assign ts_seen   = !bus.TSn;
    assign term_seen = !bus.TACKn || !bus.TEAn;

    lb_timeout_ctr #(
        .WIDTH (CTR_W)
    ) u_ctr (
        .clk   (CLK40),
        .rst_n (RESETn),
        .load  (ctr_load),
        .en    (ctr_en),
        .limit (ctr_limit),
        .tc    (ctr_tc)
    );

    // Next-state, counter control and output-register next values.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        to_cnt_d  = to_cnt_q;
        to_addr_d = to_addr_q;
        ctr_load  = 1'b0;
        ctr_en    = 1'b0;
        ctr_limit = TO_LIMIT;

        case (state_q)
            IDLE: begin
                if (ts_seen && bus.TO_EN) begin
                    state_d  = WAIT;
                    ctr_load = 1'b1;
                    shadow_d = bus.A_AMIGA;
                end
            end
            WAIT: begin
                // Priority: disable, then termination (beats the timeout on
                // the same clock), then restart on a fresh TSn, then timeout.
                if (!bus.TO_EN || term_seen) begin
                    state_d = IDLE;
                end else if (ts_seen) begin
                    ctr_load = 1'b1;
                    shadow_d = bus.A_AMIGA;
                end else if (ctr_tc) begin
                    state_d = ERR;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            ERR: begin
                // Always runs to completion, even if TO_EN has dropped.
                state_d   = RECOVER;
                ctr_load  = 1'b1;
                to_addr_d = shadow_q;
                to_cnt_d  = (to_cnt_q == 8'hFF) ? to_cnt_q : to_cnt_q + 8'd1;
            end
            RECOVER: begin
                // TSn is deliberately ignored here.
                ctr_limit = RC_LIMIT;
                if (!bus.TO_EN || ctr_tc) begin
                    state_d = IDLE;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear beats a coincident ERR increment.
        if (bus.CNT_CLR) begin
            to_cnt_d = '0;
        end

        to_tean_d = (state_d != ERR);
        to_busy_d = (state_d != IDLE);
    end

    // State, shadow address and registered outputs.
    always_ff @(posedge CLK40 or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            to_tean_q <= 1'b1;
            to_busy_q <= 1'b0;
            to_cnt_q  <= '0;
            to_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            to_tean_q <= to_tean_d;
            to_busy_q <= to_busy_d;
            to_cnt_q  <= to_cnt_d;
            to_addr_q <= to_addr_d;
        end
    end

    assign bus.TO_TEAn = to_tean_q;
    assign bus.TO_BUSY = to_busy_q;
    assign bus.TO_CNT  = to_cnt_q;
    assign bus.TO_ADDR = to_addr_q;

endmodule

// File: tb/tb_local_bus_timeout.sv
// Directed bench for local_bus_timeout with TIMEOUT_CLKS=16, RECOVER_CLKS=2.
module tb_local_bus_timeout;

    logic CLK40;
    logic RESETn;

    int total_cnt;
    int pass_cnt;
    int fail_cnt;
    int lows;

    local_bus_timeout_if bus ();

    local_bus_timeout #(
        .TIMEOUT_CLKS (16),
        .RECOVER_CLKS (2)
    ) dut (
        .CLK40  (CLK40),
        .RESETn (RESETn),
        .bus    (bus)
    );

    initial CLK40 = 1'b0;
    always #5 CLK40 = ~CLK40;

    // Hard time limit so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "time limit");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK40);
            #1;
        end
    endtask

    task automatic tick_count_lows(input int n, output int low_cnt);
        low_cnt = 0;
        repeat (n) begin
            @(posedge CLK40);
            #1;
            if (bus.TO_TEAn === 1'b0) low_cnt++;
        end
    endtask

    // One-clock TSn pulse carrying address a; sampled by the next edge.
    task automatic start(input logic [1:0] a);
        bus.TSn     = 1'b0;
        bus.A_AMIGA = a;
        tick(1);
        bus.TSn     = 1'b1;
        bus.A_AMIGA = 2'b00;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        total_cnt   = 0;
        pass_cnt    = 0;
        fail_cnt    = 0;
        RESETn      = 1'b0;
        bus.TSn     = 1'b1;
        bus.TACKn   = 1'b1;
        bus.TEAn    = 1'b1;
        bus.A_AMIGA = 2'b00;
        bus.TO_EN   = 1'b1;
        bus.CNT_CLR = 1'b0;

        // Reset values
        tick(2);
        check("rst_tean", 32'(bus.TO_TEAn), 1);
        check("rst_busy", 32'(bus.TO_BUSY), 0);
        check("rst_cnt",  32'(bus.TO_CNT), 0);
        check("rst_addr", 32'(bus.TO_ADDR), 0);

        // TSn during reset is ignored; first TSn after release is honoured
        bus.TSn = 1'b0;
        tick(1);
        check("rst_hold_busy", 32'(bus.TO_BUSY), 0);
        RESETn = 1'b1;
        tick(1);
        bus.TSn = 1'b1;
        check("first_ts_busy", 32'(bus.TO_BUSY), 1);

        // TO_EN low in WAIT drops to IDLE, no error later
        bus.TO_EN = 1'b0;
        tick(1);
        check("en_off_busy", 32'(bus.TO_BUSY), 0);
        bus.TO_EN = 1'b1;
        tick_count_lows(20, lows);
        check("en_off_no_err", 32'(lows), 0);

        // TO_EN low in IDLE: TSn not accepted
        bus.TO_EN = 1'b0;
        start(2'b00);
        check("en_off_idle_busy", 32'(bus.TO_BUSY), 0);
        bus.TO_EN = 1'b1;

        // Normal cycle: TACKn five clocks after TSn
        start(2'b00);
        tick(4);
        check("norm_busy_open", 32'(bus.TO_BUSY), 1);
        bus.TACKn = 1'b0;
        tick(1);
        bus.TACKn = 1'b1;
        check("norm_busy_fall", 32'(bus.TO_BUSY), 0);
        check("norm_tean", 32'(bus.TO_TEAn), 1);
        check("norm_cnt", 32'(bus.TO_CNT), 0);

        // TEAn terminates too
        start(2'b01);
        tick(2);
        bus.TEAn = 1'b0;
        tick(1);
        bus.TEAn = 1'b1;
        check("tea_busy", 32'(bus.TO_BUSY), 0);
        tick_count_lows(20, lows);
        check("tea_no_err", 32'(lows), 0);

        // Timeout with A_AMIGA=10
        start(2'b10);
        tick_count_lows(15, lows);
        check("to_no_early_err", 32'(lows), 0);
        check("to_busy_wait", 32'(bus.TO_BUSY), 1);
        tick(1);
        check("to_tean_low", 32'(bus.TO_TEAn), 0);
        check("to_busy_err", 32'(bus.TO_BUSY), 1);
        tick(1);
        check("to_tean_one_clk", 32'(bus.TO_TEAn), 1);
        check("to_addr", 32'(bus.TO_ADDR), 2);
        check("to_cnt", 32'(bus.TO_CNT), 1);
        tick(1);
        check("to_busy_recover", 32'(bus.TO_BUSY), 1);
        tick(1);
        check("to_busy_idle", 32'(bus.TO_BUSY), 0);

        // Race: TACKn on the 16th clock wins
        start(2'b01);
        tick(15);
        bus.TACKn = 1'b0;
        tick(1);
        bus.TACKn = 1'b1;
        check("race_tean", 32'(bus.TO_TEAn), 1);
        check("race_busy", 32'(bus.TO_BUSY), 0);
        tick_count_lows(5, lows);
        check("race_no_err", 32'(lows), 0);
        check("race_cnt", 32'(bus.TO_CNT), 1);
        check("race_addr", 32'(bus.TO_ADDR), 2);

        // Restart: second TSn on clock 10 of WAIT
        start(2'b01);
        tick(9);
        start(2'b11);
        tick_count_lows(15, lows);
        check("restart_no_early_err", 32'(lows), 0);
        tick(1);
        check("restart_tean_low", 32'(bus.TO_TEAn), 0);
        tick(1);
        check("restart_addr", 32'(bus.TO_ADDR), 3);
        check("restart_cnt", 32'(bus.TO_CNT), 2);
        // TSn inside RECOVER is ignored
        start(2'b00);
        tick(1);
        check("recover_ignores_ts", 32'(bus.TO_BUSY), 0);
        tick_count_lows(20, lows);
        check("recover_ts_no_err", 32'(lows), 0);

        // TO_EN dropped in ERR: ERR completes, RECOVER is cut short
        start(2'b00);
        tick(16);
        check("en_err_tean_low", 32'(bus.TO_TEAn), 0);
        bus.TO_EN = 1'b0;
        tick(1);
        check("en_err_tean", 32'(bus.TO_TEAn), 1);
        check("en_err_cnt", 32'(bus.TO_CNT), 3);
        check("en_err_addr", 32'(bus.TO_ADDR), 0);
        check("en_err_busy_rec", 32'(bus.TO_BUSY), 1);
        tick(1);
        check("en_err_busy_idle", 32'(bus.TO_BUSY), 0);
        bus.TO_EN = 1'b1;

        // Reset at clock 8 of WAIT
        start(2'b01);
        tick(8);
        RESETn = 1'b0;
        #1;
        check("midrst_tean", 32'(bus.TO_TEAn), 1);
        check("midrst_busy", 32'(bus.TO_BUSY), 0);
        check("midrst_cnt", 32'(bus.TO_CNT), 0);
        check("midrst_addr", 32'(bus.TO_ADDR), 0);
        @(negedge CLK40);
        RESETn = 1'b1;
        tick_count_lows(30, lows);
        check("midrst_no_err", 32'(lows), 0);
        check("midrst_busy_after", 32'(bus.TO_BUSY), 0);

        // Saturation over 260 timeouts
        repeat (260) begin
            start(2'b10);
            tick(19);
        end
        check("sat_cnt", 32'(bus.TO_CNT), 255);
        check("sat_busy", 32'(bus.TO_BUSY), 0);

        // CNT_CLR on the ERR clock beats the increment
        start(2'b01);
        tick(16);
        check("clr_tean_low", 32'(bus.TO_TEAn), 0);
        bus.CNT_CLR = 1'b1;
        tick(1);
        bus.CNT_CLR = 1'b0;
        check("clr_cnt", 32'(bus.TO_CNT), 0);
        check("clr_addr", 32'(bus.TO_ADDR), 1);
        tick(2);
        start(2'b11);
        tick(19);
        check("clr_then_cnt", 32'(bus.TO_CNT), 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/local_bus_timeout.md
LOCAL_BUS_TIMEOUT -- requirements
Module: local_bus_timeout

Interface
REQ-001 Parameter TIMEOUT_CLKS, default 1023: CLK40 cycles allowed between transfer start and termination before a forced bus error.
REQ-002 Parameter RECOVER_CLKS, default 2: idle CLK40 cycles enforced after a forced bus error.
REQ-003 CLK40  input  1  bus clock; all logic is on its rising edge.
REQ-004 RESETn  input  1  asynchronous, active-low reset.
REQ-005 TSn  input  1  Amiga-side transfer start, active low, one-clock pulse.
REQ-006 TACKn  input  1  target transfer acknowledge, active low.
REQ-007 TEAn  input  1  target transfer error, active low.
REQ-008 A_AMIGA  input  2  Amiga-side low address bits, valid on the TSn clock.
REQ-009 TO_EN  input  1  watchdog enable, active high.
REQ-010 CNT_CLR  input  1  synchronous clear of the fault counter, active high.
REQ-011 TO_TEAn  output  1  forced transfer error toward the sizing logic, active low.
REQ-012 TO_BUSY  output  1  high while a monitored cycle is open.
REQ-013 TO_CNT  output  8  saturating count of forced errors.
REQ-014 TO_ADDR  output  2  A_AMIGA captured for the most recent timed-out cycle.

Function
REQ-015 The block SHALL implement four states: IDLE, WAIT, ERR, RECOVER.
REQ-016 IDLE->WAIT SHALL occur when TSn=0 and TO_EN=1; the counter loads 0 and A_AMIGA is captured into a shadow register.
REQ-017 In WAIT, the counter SHALL increment by 1 per clock and SHALL be wide enough, at $clog2(TIMEOUT_CLKS+1) bits, that it never wraps.
REQ-018 WAIT->IDLE SHALL occur on any clock where TACKn=0 or TEAn=0, with no error forced.
REQ-019 WAIT->ERR SHALL occur when the counter equals TIMEOUT_CLKS-1 and TACKn=1 and TEAn=1, so that the error is forced on the TIMEOUT_CLKS-th clock after TSn.
REQ-020 If a termination and the timeout limit occur on the same clock, termination SHALL win: go to IDLE with no error.
REQ-021 If TSn=0 while in WAIT, the counter SHALL restart at 0 and the shadow address SHALL be recaptured; no error is forced.
REQ-022 In ERR, TO_TEAn SHALL be 0 for exactly one clock, TO_ADDR SHALL load the shadow address, and TO_CNT SHALL increment, saturating at 255.
REQ-023 ERR->RECOVER SHALL be unconditional; RECOVER SHALL last RECOVER_CLKS clocks, ignore TSn, and then return to IDLE.
REQ-024 TO_EN=0 SHALL force IDLE from WAIT or RECOVER on the next clock; an ERR already entered SHALL complete its single cycle.
REQ-025 TO_BUSY SHALL be 1 in WAIT, ERR and RECOVER, and 0 in IDLE.
REQ-026 CNT_CLR=1 SHALL zero TO_CNT; if it coincides with an ERR increment, the clear SHALL win.
REQ-027 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-028 While RESETn=0, the state SHALL be IDLE and the counter 0, with TO_TEAn=1, TO_BUSY=0, TO_CNT=0 and TO_ADDR=0.
REQ-029 Reset asserted mid-cycle (WAIT, ERR or RECOVER) SHALL abandon the cycle without emitting TO_TEAn.
REQ-030 After RESETn deasserts, the first TSn SHALL be honoured on the following clock edge.

Structure
REQ-031 State encodings and the default TIMEOUT_CLKS and RECOVER_CLKS values SHALL reside in the shared package local_bus_pkg.
REQ-032 The timeout counter SHALL be a sub-module, lb_timeout_ctr, with load, enable and terminal-count ports; the rest of the block is flat.
REQ-033 At the top level, TO_TEAn SHALL be ANDed with the target TEAn before the result feeds the sizing state machine; that logic is outside this block.

Verification (TIMEOUT_CLKS=16, RECOVER_CLKS=2)
REQ-034 Normal cycle: TSn pulse, then TACKn=0 five clocks later -> TO_BUSY falls the clock after TACKn, TO_TEAn stays 1, TO_CNT=0.
REQ-035 Timeout: TSn with A_AMIGA=2'b10 and no termination -> TO_TEAn=0 for one clock on the 16th clock after TSn, then TO_ADDR=2'b10, TO_CNT=1, and TO_BUSY=0 three clocks later.
REQ-036 Race: TACKn=0 on exactly the 16th clock -> no TO_TEAn, TO_CNT unchanged.
REQ-037 Re-start: a second TSn on clock 10 of WAIT -> the error is forced 16 clocks after the second TSn, not the first.
REQ-038 Reset at clock 8 of WAIT -> all outputs at reset values, and no TO_TEAn pulse afterwards without a new TSn.
REQ-039 Saturation and clear: 260 timeouts -> TO_CNT=255; then CNT_CLR held on an ERR clock -> TO_CNT=0.
